// File: rtl/bus_pkg.sv
// Shared RAM bus definitions: widths, request beat layout and the read/write test.
package bus_pkg;

    localparam int BUS_ADDR_W = 30;
    localparam int BUS_DATA_W = 32;
    localparam int BUS_MASK_W = 4;

    typedef struct packed {
        logic [BUS_ADDR_W-1:0] addr;
        logic [BUS_DATA_W-1:0] data_w;
        logic [BUS_MASK_W-1:0] mask_w;
    } bus_req_t;

    // An all-zero byte mask marks a read beat.
    function automatic logic is_read(input logic [BUS_MASK_W-1:0] mask);
        return mask == '0;
    endfunction

endpackage

// File: rtl/bus_arb_pick.sv
// Combinational priority picker: first set bit of valid, searching upward from start and wrapping.
// Latency 0; no backpressure of its own (pure function of its inputs).
module bus_arb_pick #(
    parameter int N = 2
) (
    input  logic [N-1:0]         valid,
    input  logic [$clog2(N)-1:0] start,
    output logic [N-1:0]         grant
);

    localparam int IW = $clog2(N);

    logic [IW:0] pos;
    logic        found;

    always_comb begin
        grant = '0;
        found = 1'b0;
        pos   = '0;
        for (int k = 0; k < N; k++) begin
            // start + k fits in IW+1 bits, so one subtraction is a full modulo N
            pos = {1'b0, start} + (IW+1)'(k);
            if (pos >= (IW+1)'(N))
                pos = pos - (IW+1)'(N);
            if (!found && valid[pos[IW-1:0]]) begin
                grant[pos[IW-1:0]] = 1'b1;
                found              = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// Shares the single-port RAM bus among NREQ requesters; routes read data back to its owner.
// Grant is same-cycle (req_ready combinational); read data returns exactly one cycle after acceptance.
// Backpressure: losers see req_ready=0 and hold; a locked owner keeps the bus. BUS_ARB_RR_EN selects round-robin.
module bus_arbiter
    import bus_pkg::*;
#(
    parameter int NREQ   = 2,
    parameter int ADDR_W = BUS_ADDR_W
) (
    input  logic                                clock,
    input  logic                                reset,
    input  logic [NREQ-1:0]                     req_valid,
    output logic [NREQ-1:0]                     req_ready,
    input  logic [NREQ-1:0]                     req_lock,
    input  logic [NREQ-1:0][ADDR_W-1:0]         req_addr,
    input  logic [NREQ-1:0][BUS_DATA_W-1:0]     req_data_w,
    input  logic [NREQ-1:0][BUS_MASK_W-1:0]     req_mask_w,
    output logic [NREQ-1:0]                     rsp_valid,
    output logic [BUS_DATA_W-1:0]               rsp_data,
    output logic [ADDR_W-1:0]                   bus_addr,
    output logic [BUS_DATA_W-1:0]               bus_data_w,
    output logic [BUS_MASK_W-1:0]               bus_mask_w,
    input  logic [BUS_DATA_W-1:0]               bus_data_r
);

    localparam int IW = $clog2(NREQ);

    logic [NREQ-1:0] pick_grant;
    logic [NREQ-1:0] grant;
    logic [IW-1:0]   start;
    logic [IW-1:0]   grant_idx;
    logic [IW-1:0]   lock_idx;
    logic [IW-1:0]   rd_owner;
    logic            lock_vld;
    logic            lock_hit;
    logic            hs;
    logic            rd_pending;

`ifdef BUS_ARB_RR_EN
    logic [IW-1:0] rr_ptr;

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            rr_ptr <= '0;
        else if (hs)
            rr_ptr <= (grant_idx == IW'(NREQ-1)) ? '0 : grant_idx + 1'b1;
    end

    assign start = rr_ptr;
`else
    assign start = '0;
`endif

    bus_arb_pick #(.N(NREQ)) u_pick (
        .valid (req_valid),
        .start (start),
        .grant (pick_grant)
    );

    // The lock only holds while its owner keeps requesting.
    assign lock_hit = lock_vld && req_valid[lock_idx];

    always_comb begin
        grant = pick_grant;
        if (lock_hit) begin
            grant           = '0;
            grant[lock_idx] = 1'b1;
        end
    end

    always_comb begin
        grant_idx = '0;
        for (int i = 0; i < NREQ; i++)
            if (grant[i])
                grant_idx = IW'(i);
    end

    assign hs        = |grant;
    assign req_ready = grant;

    always_comb begin
        bus_addr   = '0;
        bus_data_w = '0;
        bus_mask_w = '0;
        if (hs) begin
            bus_addr   = req_addr[grant_idx];
            bus_data_w = req_data_w[grant_idx];
            bus_mask_w = req_mask_w[grant_idx];
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_pending <= 1'b0;
            rd_owner   <= '0;
            lock_vld   <= 1'b0;
            lock_idx   <= '0;
        end else begin
            rd_pending <= hs && is_read(req_mask_w[grant_idx]);
            if (hs) begin
                rd_owner <= grant_idx;
                lock_vld <= req_lock[grant_idx];
                lock_idx <= grant_idx;
            end else if (lock_vld && !req_valid[lock_idx]) begin
                lock_vld <= 1'b0;
            end
        end
    end

    always_comb begin
        rsp_valid = '0;
        if (rd_pending)
            rsp_valid[rd_owner] = 1'b1;
    end

    // RAM output is already registered; the response is a straight pass-through.
    assign rsp_data = bus_data_r;

endmodule
